dmem_access_unit: RTL and testbench
===================================

# dmem_access_unit

Memory-stage front end for the word-wide data RAM. It accepts byte, halfword and word load/store requests from the MEM pipeline stage and drives the RAM's word-indexed port. Sub-word stores use read-modify-write; sub-word loads are lane-extracted and zero- or sign-extended. Misaligned accesses are rejected without touching memory. While a request is in flight, the unit holds the pipeline off through `req_ready`.

## Interface
- `ADDR_W`, 32: byte-address width of requests.
- `DATA_W`, 32: data width; fixed at 32 (4 byte lanes).

Clocking: one clock; reset is asynchronous and active-low.

- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request; high only in IDLE.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_signed` input 1: sign-extend loads; ignored for stores and word loads.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified.
- `resp_valid` output 1: one-cycle pulse marking completion.
- `resp_err` output 1: qualifies `resp_valid`; misaligned or reserved size.
- `resp_rdata` output 32: load result; 0 for stores and errors.
- `ram_we` output 1: RAM write enable.
- `ram_addr` output 32: word index, `{2'b00, addr[31:2]}`.
- `ram_din` output 32: RAM write data.
- `ram_dout` input 32: RAM read data; combinational, shows `ram_din` while `ram_we` is high.

## Operation
- **Accept:** a request is accepted on an edge where `req_valid && req_ready`. Address, size, signed, wdata and write are latched at that edge; inputs are ignored afterwards.
- **Lanes** (little-endian):
  - byte at `addr[1:0]`=k occupies bits [8k+7:8k].
  - half at `addr[1]`=h occupies bits [16h+15:16h].
- **Error check:** an error is flagged for half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11. On error:
  - no RAM access occurs and the FSM stays IDLE;
  - `resp_valid`=1 and `resp_err`=1 the next cycle, with `resp_rdata`=0.
- **FSM states:** IDLE, LOAD, RMW_READ, WRITE.
  - IDLE → LOAD for a load; → WRITE for a word store; → RMW_READ for a byte/half store; stays IDLE on error.
  - LOAD: `ram_addr` = latched index. Selected lane of `ram_dout` is extended (sign if `req_signed`, else zero) into `resp_rdata`. → IDLE, with `resp_valid`=1 next cycle.
  - RMW_READ: `ram_dout` is captured into the merge register, and the latched store lane(s) replace the target bytes. → WRITE.
  - WRITE: `ram_we`=1; `ram_din` = merged word (sub-word) or latched wdata (word). → IDLE, with `resp_valid`=1, `resp_err`=0, `resp_rdata`=0 next cycle.
- **Idle outputs:** `ram_we`=0 and `ram_din`=0 outside WRITE; `ram_addr` = latched index in every non-IDLE state.
- **Address wrap:** the RAM decodes index bits [6:0], so byte addresses alias every 512 bytes. The unit does not range-check.

## Timing
- **Reset values:** state IDLE; `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, latched fields 0; `ram_we`=0, `ram_din`=0, `ram_addr`=0. `req_ready`=1 once reset deasserts.
- **Latency** (accept edge to `resp_valid` high):
  - error: 1 cycle;
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles.
- **Response overlap:** `resp_valid` is high in the first IDLE cycle after completion, so a new request may be accepted in that same cycle. Peak throughput is one load per 2 cycles.
- **Stability:** `resp_rdata` and `resp_err` are updated only on edges that set `resp_valid`. They hold their values otherwise.
- **Reset mid-operation:**
  - Asserting `rst_n` low forces IDLE asynchronously, and `ram_we` drops combinationally.
  - A WRITE cycle interrupted before its edge commits nothing.
  - An aborted RMW leaves memory unchanged, and no response is produced.
- **Flow control:** `req_valid` held high while `req_ready`=0 is ignored and must not be double-accepted.

## Test plan
- Word store then word load: sw 0x0000_0010 ← 0xDEADBEEF, then lw 0x10 → `resp_rdata`=0xDEADBEEF, `resp_err`=0. Response is 2 cycles after each accept, and `ram_we` is high for exactly one cycle.
- Byte store RMW: preload word 0x20 = 0x11223344, sb 0x22 ← 0xAB → RAM word becomes 0x11AB3344. The response comes 3 cycles after accept; the previous response pulse overlaps the next accept.
- Extension: word 0x30 = 0x0000_8080.
  - lb 0x30 → 0xFFFFFF80;
  - lbu 0x30 → 0x00000080;
  - lh 0x30 → 0xFFFF8080;
  - lhu 0x30 → 0x00008080.
- Errors: lw 0x05, sh 0x33 and size=11 each give `resp_valid`=`resp_err`=1 after 1 cycle, with `ram_we` never asserted and memory unchanged.
- Reset mid-RMW: sb issued, `rst_n` pulsed low during RMW_READ → no write and no `resp_valid`; after release, `req_ready`=1 and memory is unchanged.
- Aliasing: sw 0x200 ← 0xCAFEF00D, then lw 0x0 → 0xCAFEF00D.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Memory-stage access unit: byte/half/word loads and stores onto a word-indexed data RAM.
// Sub-word stores use read-modify-write; misaligned or reserved-size requests are rejected.
module dmem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   typedef enum logic [1:0] {IDLE, LOAD, RMW_READ, WRITE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic              signed_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] merge_q;

   logic              accept;
   logic              req_err;
   logic [DATA_W-1:0] byte_sel;
   logic [DATA_W-1:0] half_sel;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] merged;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign req_err   = (req_size == 2'b11)
                    || (req_size == 2'b01 && req_addr[0])
                    || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && !req_err) begin
               if (!req_write)              state_nxt = LOAD;
               else if (req_size == 2'b10)  state_nxt = WRITE;
               else                         state_nxt = RMW_READ;
            end
         end
         LOAD:     state_nxt = IDLE;
         RMW_READ: state_nxt = WRITE;
         WRITE:    state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Lane extraction: shift the addressed lane down to bit 0, then extend.
   assign byte_sel = ram_dout >> {addr_q[1:0], 3'b000};
   assign half_sel = ram_dout >> {addr_q[1], 4'b0000};

   always_comb begin
      load_data = ram_dout;
      case (size_q)
         2'b00:   load_data = signed_q ? {{24{byte_sel[7]}}, byte_sel[7:0]}
                                       : {24'b0, byte_sel[7:0]};
         2'b01:   load_data = signed_q ? {{16{half_sel[15]}}, half_sel[15:0]}
                                       : {16'b0, half_sel[15:0]};
         default: load_data = ram_dout;
      endcase
   end

   always_comb begin
      merged = ram_dout;
      if (size_q == 2'b00) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (addr_q[1:0] == i[1:0]) merged[8*i +: 8] = wdata_q[7:0];
         end
      end else if (size_q == 2'b01) begin
         if (addr_q[1]) merged[31:16] = wdata_q[15:0];
         else           merged[15:0]  = wdata_q[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr_q     <= '0;
         size_q     <= '0;
         signed_q   <= 1'b0;
         wdata_q    <= '0;
         merge_q    <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         state      <= state_nxt;
         resp_valid <= 1'b0;
         if (accept) begin
            addr_q   <= req_addr;
            size_q   <= req_size;
            signed_q <= req_signed;
            wdata_q  <= req_wdata;
         end
         if (state == RMW_READ) merge_q <= merged;
         case (state)
            IDLE: begin
               if (accept && req_err) begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end
            end
            LOAD: begin
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= load_data;
            end
            WRITE: begin
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
            default: ;
         endcase
      end
   end

   assign ram_we   = (state == WRITE);
   assign ram_addr = {2'b00, addr_q[ADDR_W-1:2]};
   assign ram_din  = ram_we ? ((size_q == 2'b10) ? wdata_q : merge_q) : '0;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: bench-side RAM, transaction-level reference model,
// per-cycle output comparison plus literal spot checks from the test plan.
module tb_dmem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;

   dmem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
      .resp_rdata(resp_rdata), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Word RAM: 128 words, index bits [6:0], read-through of din while writing.
   logic [31:0] mem [128];
   logic [31:0] ref_mem [128];
   assign ram_dout = ram_we ? ram_din : mem[ram_addr[6:0]];
   always @(posedge clk) if (ram_we) mem[ram_addr[6:0]] <= ram_din;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;
   int we_cycles = 0;
   logic [31:0] dut_last_rd = '0;
   logic        last_err = 1'b0;
   logic [31:0] last_rd  = '0;

   typedef struct { int cyc; logic err; logic [31:0] rdata; } resp_t;
   typedef struct { int cyc; logic [31:0] addr; logic [31:0] din; } wr_t;
   resp_t rq[$];
   wr_t   wq[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] sz,
                                            input logic sg, input logic [31:0] a);
      int unsigned bits, off, v;
      if (sz == 2'b10) return w;
      bits = (sz == 2'b00) ? 8 : 16;
      off  = (sz == 2'b00) ? 8 * a[1:0] : 16 * a[1];
      v    = (w >> off) & ((32'd1 << bits) - 1);
      if (sg && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
      return v;
   endfunction

   function automatic logic [31:0] st_model(input logic [31:0] old, input logic [1:0] sz,
                                            input logic [31:0] a, input logic [31:0] wd);
      int unsigned bits, off;
      logic [31:0] m;
      if (sz == 2'b10) return wd;
      bits = (sz == 2'b00) ? 8 : 16;
      off  = (sz == 2'b00) ? 8 * a[1:0] : 16 * a[1];
      m    = ((32'd1 << bits) - 1) << off;
      return (old & ~m) | ((wd << off) & m);
   endfunction

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         bit ev, ew;
         ev = rq.size() > 0 && rq[0].cyc == cyc;
         chk("resp_valid", {31'b0, resp_valid}, {31'b0, ev});
         if (ev) begin
            last_err = rq[0].err;
            last_rd  = rq[0].rdata;
         end
         if (rq.size() > 0 && rq[0].cyc <= cyc) void'(rq.pop_front());
         chk("resp_err", {31'b0, resp_err}, {31'b0, last_err});
         chk("resp_rdata", resp_rdata, last_rd);
         if (resp_valid) dut_last_rd = resp_rdata;
         ew = wq.size() > 0 && wq[0].cyc == cyc;
         chk("ram_we", {31'b0, ram_we}, {31'b0, ew});
         if (ram_we) we_cycles++;
         if (ew) begin
            chk("ram_addr", ram_addr, wq[0].addr);
            chk("ram_din", ram_din, wq[0].din);
         end else begin
            chk("ram_din_idle", ram_din, 32'h0);
         end
         if (wq.size() > 0 && wq[0].cyc <= cyc) void'(wq.pop_front());
      end
   end

   task automatic req(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input bit hold, input bit abort_op, output bit ov);
      bit e;
      int c, n, lat;
      logic [6:0] idx;
      logic [31:0] nw;
      resp_t r;
      wr_t wr;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      if (!req_ready) chk("ready_timeout", {31'b0, req_ready}, 32'h1);
      c  = cyc;
      ov = resp_valid;
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      idx = a[8:2];
      e = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      if (!abort_op) begin
         if (e) begin
            r = '{c + 1, 1'b1, 32'h0}; rq.push_back(r);
         end else if (!w) begin
            r = '{c + 2, 1'b0, ld_model(ref_mem[idx], sz, sg, a)}; rq.push_back(r);
         end else begin
            lat = (sz == 2'b10) ? 2 : 3;
            nw  = st_model(ref_mem[idx], sz, a, wd);
            wr  = '{c + lat - 1, {2'b00, a[31:2]}, nw}; wq.push_back(wr);
            r   = '{c + lat, 1'b0, 32'h0}; rq.push_back(r);
            ref_mem[idx] = nw;
         end
      end
      @(posedge clk); #1;
      req_addr = 32'hFFFF_FFFF; req_wdata = $urandom; req_size = 2'b11; req_write = ~w;
      if (hold) begin
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready) break;
         end
      end
      req_valid = 1'b0;
      if (abort_op) begin
         #2 rst_n = 1'b0;
         #1;
         chk("abort_we", {31'b0, ram_we}, 32'h0);
         chk("abort_valid", {31'b0, resp_valid}, 32'h0);
         @(negedge clk); #2 rst_n = 1'b1;
         last_err = 1'b0; last_rd = '0;
         @(negedge clk);
         chk("abort_ready", {31'b0, req_ready}, 32'h1);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((rq.size() > 0 || wq.size() > 0) && n < 50) begin @(negedge clk); n++; end
      chk("drain_timeout", rq.size() + wq.size(), 32'h0);
   endtask

   bit ov;
   int we0;
   int diffs;

   initial begin
      for (int i = 0; i < 128; i++) begin mem[i] = '0; ref_mem[i] = '0; end
      mem[8]  = 32'h1122_3344; ref_mem[8]  = 32'h1122_3344;
      mem[12] = 32'h0000_8080; ref_mem[12] = 32'h0000_8080;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0;
      @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'b0, req_ready}, 32'h1);
      chk("rst_valid", {31'b0, resp_valid}, 32'h0);
      chk("rst_err", {31'b0, resp_err}, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_we", {31'b0, ram_we}, 32'h0);
      chk("rst_din", ram_din, 32'h0);
      chk("rst_addr", ram_addr, 32'h0);
      chk_en = 1'b1;

      we0 = we_cycles;
      req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, 0, ov);
      req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 0, ov);
      wait_idle();
      chk("lw_deadbeef", dut_last_rd, 32'hDEAD_BEEF);
      chk("sw_we_once", we_cycles - we0, 32'd1);

      req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, 0, ov);
      req(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AB, 0, 0, ov);
      chk("overlap_accept", {31'b0, ov}, 32'h1);
      wait_idle();
      chk("sb_mem", mem[8], 32'h11AB_3344);

      req(1'b0, 2'b00, 1'b1, 32'h30, 32'h0, 0, 0, ov); wait_idle();
      chk("lb", dut_last_rd, 32'hFFFF_FF80);
      req(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 0, 0, ov); wait_idle();
      chk("lbu", dut_last_rd, 32'h0000_0080);
      req(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 0, 0, ov); wait_idle();
      chk("lh", dut_last_rd, 32'hFFFF_8080);
      req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 0, 0, ov); wait_idle();
      chk("lhu", dut_last_rd, 32'h0000_8080);

      we0 = we_cycles;
      req(1'b0, 2'b10, 1'b0, 32'h05, 32'h0, 0, 0, ov);
      req(1'b1, 2'b01, 1'b0, 32'h33, 32'h1234, 0, 0, ov);
      req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 0, 0, ov);
      req(1'b1, 2'b11, 1'b0, 32'h20, 32'h5555_5555, 0, 0, ov);
      wait_idle();
      chk("err_no_we", we_cycles - we0, 32'd0);

      req(1'b1, 2'b01, 1'b0, 32'h26, 32'h0000_5A5A, 1, 0, ov);
      req(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFC3, 1, 0, ov);
      req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 0, 0, ov);
      req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_9001, 0, 0, ov);
      req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0, 0, ov);
      req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, 0, ov);
      wait_idle();

      we0 = we_cycles;
      req(1'b1, 2'b00, 1'b0, 32'h24, 32'h0000_0077, 0, 1, ov);
      chk("abort_no_we", we_cycles - we0, 32'd0);
      chk("abort_mem", mem[9], ref_mem[9]);

      req(1'b1, 2'b10, 1'b0, 32'h200, 32'hCAFE_F00D, 0, 0, ov);
      req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, 0, ov);
      wait_idle();
      chk("alias_lw", dut_last_rd, 32'hCAFE_F00D);

      diffs = 0;
      for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) diffs++;
      chk("mem_image", diffs, 32'd0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1);
   end

endmodule
